// File: rtl/ieee_adder_arbiter_pkg.sv
// Shared widths, state encoding and small helpers for the arbitrated FP adder.
package ieee_adder_arbiter_pkg;

   localparam int FP_W    = 32;
   localparam int EXP_W   = 8;
   localparam int MANT_W  = 23;
   localparam int SIG_W   = MANT_W + 1;
   localparam int GRD_W   = 3;
   localparam int EXT_W   = SIG_W + GRD_W;
   localparam int OWNER_W = 1;
   localparam int STATE_W = 2;

   localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Denormals share the exponent of the smallest normal.
   function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
      return (e == '0) ? EXP_W'(1) : e;
   endfunction

   // Significand with the hidden bit restored (zero for denormals).
   function automatic logic [SIG_W-1:0] sig_of(input logic [EXP_W-1:0] e,
                                               input logic [MANT_W-1:0] m);
      return {(e != '0), m};
   endfunction

endpackage

// File: rtl/ieee_adder_arbiter_fadd.sv
// Combinational IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
module ieee_adder_arbiter_fadd
   import ieee_adder_arbiter_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   input  logic            sub,
   output logic [FP_W-1:0] result
);

   logic              sign_a, sign_b, a_big;
   logic [EXP_W-1:0]  exp_a, exp_b;
   logic [MANT_W-1:0] man_a, man_b;
   logic              nan_a, nan_b, inf_a, inf_b;
   logic              sign_l, sign_s, eff_sub;
   logic [EXP_W-1:0]  exp_l, exp_s, exp_diff;
   logic [SIG_W-1:0]  sig_l, sig_s;
   logic [EXT_W-1:0]  ext_s, aligned, lost_mask;
   logic [EXT_W:0]    sum;
   logic [EXT_W-1:0]  norm;
   logic [4:0]        lzc;
   logic              found;
   logic [9:0]        exp_n, shamt, exp_r;
   logic              round_up;
   logic [SIG_W:0]    rounded;
   logic [SIG_W-1:0]  sig_r;

   // Unpack operands and order them so the larger magnitude is on the left.
   always_comb begin
      sign_a = a[FP_W-1];
      sign_b = b[FP_W-1] ^ sub;
      exp_a  = a[FP_W-2 -: EXP_W];
      exp_b  = b[FP_W-2 -: EXP_W];
      man_a  = a[MANT_W-1:0];
      man_b  = b[MANT_W-1:0];
      nan_a  = (&exp_a) && (|man_a);
      nan_b  = (&exp_b) && (|man_b);
      inf_a  = (&exp_a) && !(|man_a);
      inf_b  = (&exp_b) && !(|man_b);
      a_big  = (a[FP_W-2:0] >= b[FP_W-2:0]);
      sign_l = a_big ? sign_a : sign_b;
      sign_s = a_big ? sign_b : sign_a;
      exp_l  = a_big ? eff_exp(exp_a) : eff_exp(exp_b);
      exp_s  = a_big ? eff_exp(exp_b) : eff_exp(exp_a);
      sig_l  = a_big ? sig_of(exp_a, man_a) : sig_of(exp_b, man_b);
      sig_s  = a_big ? sig_of(exp_b, man_b) : sig_of(exp_a, man_a);
      eff_sub = sign_l ^ sign_s;
   end

   // Align the smaller operand, fold shifted-out bits into sticky, then add.
   always_comb begin
      exp_diff  = exp_l - exp_s;
      ext_s     = {sig_s, {GRD_W{1'b0}}};
      lost_mask = '0;
      if (exp_diff >= EXP_W'(EXT_W)) begin
         aligned = {{(EXT_W-1){1'b0}}, |sig_s};
      end else begin
         lost_mask = (EXT_W'(1) << exp_diff) - EXT_W'(1);
         aligned   = (ext_s >> exp_diff) | {{(EXT_W-1){1'b0}}, |(ext_s & lost_mask)};
      end
      if (eff_sub)
         sum = {1'b0, sig_l, {GRD_W{1'b0}}} - {1'b0, aligned};
      else
         sum = {1'b0, sig_l, {GRD_W{1'b0}}} + {1'b0, aligned};
   end

   // Normalise: right by one on carry-out, otherwise left by the leading-zero
   // count, clamped so the exponent never drops below the denormal level.
   always_comb begin
      lzc   = 5'(EXT_W);
      found = 1'b0;
      for (int i = EXT_W-1; i >= 0; i--) begin
         if (!found && sum[i]) begin
            lzc   = 5'(EXT_W-1-i);
            found = 1'b1;
         end
      end
      exp_n = {2'b00, exp_l};
      shamt = '0;
      if (sum[EXT_W]) begin
         norm  = {sum[EXT_W:2], sum[1] | sum[0]};
         exp_n = exp_n + 10'd1;
      end else begin
         shamt = ({5'b0, lzc} < exp_n) ? {5'b0, lzc} : (exp_n - 10'd1);
         norm  = sum[EXT_W-1:0] << shamt;
         exp_n = exp_n - shamt;
      end
   end

   // Round to nearest even, then handle specials, zero and overflow.
   always_comb begin
      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      rounded  = {1'b0, norm[EXT_W-1:GRD_W]} + {{SIG_W{1'b0}}, round_up};
      sig_r    = rounded[SIG_W-1:0];
      exp_r    = exp_n;
      if (rounded[SIG_W]) begin
         sig_r = rounded[SIG_W:1];
         exp_r = exp_n + 10'd1;
      end
      if (nan_a || nan_b || (inf_a && inf_b && (sign_a ^ sign_b)))
         result = QNAN;
      else if (inf_a)
         result = {sign_a, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      else if (inf_b)
         result = {sign_b, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      else if (sum == '0)
         result = {(eff_sub ? 1'b0 : sign_l), {(FP_W-1){1'b0}}};
      else if (exp_r >= 10'd255)
         result = {sign_l, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      else
         result = {sign_l, (sig_r[SIG_W-1] ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}),
                   sig_r[MANT_W-1:0]};
   end

endmodule

// File: rtl/ieee_adder_arbiter.sv
// Two-requester front end sharing one FP adder; one operation in flight.
//
// state   | meaning
// IDLE    | waiting for a request; grant is combinational
// EXEC    | registered operands through the adder, result captured
// RESP    | result presented to the owner until it accepts
module ieee_adder_arbiter
   import ieee_adder_arbiter_pkg::*;
#(
   parameter int RR_ENABLE = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_b0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b1,
   input  logic [1:0]  req_sub,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_result,
   output logic        busy
);

   state_t               state_q, state_d;
   logic [OWNER_W-1:0]   owner_q, last_owner_q, grant;
   logic [FP_W-1:0]      op_a_q, op_b_q, sum;
   logic                 op_sub_q;
   logic                 req_fire;

   ieee_adder_arbiter_fadd u_fadd (
      .a      (op_a_q),
      .b      (op_b_q),
      .sub    (op_sub_q),
      .result (sum)
   );

   // Pick a winner: alternate on a tie in round-robin mode, else requester 0.
   always_comb begin
      grant = '0;
      if ((RR_ENABLE != 0) && (req_valid == 2'b11))
         grant = ~last_owner_q;
      else if (!req_valid[0] && req_valid[1])
         grant = '1;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      req_fire  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!reset && (|req_valid)) begin
               req_ready[grant] = 1'b1;
               req_fire         = 1'b1;
               state_d          = ST_EXEC;
            end
         end
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: begin
            rsp_valid[owner_q] = 1'b1;
            if (rsp_ready[owner_q])
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture the granted operands on accept and the adder output in EXEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_sub_q     <= 1'b0;
         owner_q      <= '0;
         last_owner_q <= '1;
         rsp_result   <= '0;
      end else begin
         if (req_fire) begin
            op_a_q       <= grant[0] ? req_a1 : req_a0;
            op_b_q       <= grant[0] ? req_b1 : req_b0;
            op_sub_q     <= req_sub[grant];
            owner_q      <= grant;
            last_owner_q <= grant;
         end
         if (state_q == ST_EXEC)
            rsp_result <= sum;
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ieee_adder_arbiter.sv
// Directed bench for the arbitrated FP adder; expected results hand-computed.
module tb_ieee_adder_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_sub, rsp_ready;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0]  req_ready, rsp_valid, fx_req_ready, fx_rsp_valid;
   logic [31:0] rsp_result, fx_rsp_result;
   logic        busy, fx_busy;
   int          n_chk = 0;
   int          n_pass = 0;
   logic [1:0]  g;

   always #5 clk = ~clk;

   ieee_adder_arbiter #(.RR_ENABLE(1)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .req_sub(req_sub),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .busy(busy)
   );

   ieee_adder_arbiter #(.RR_ENABLE(0)) u_fixed (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(fx_req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .req_sub(req_sub),
      .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(fx_rsp_result),
      .busy(fx_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Full request/response from IDLE back to IDLE with zero-wait response.
   task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_res, input string tag);
      logic [1:0] oh;
      oh = (idx == 0) ? 2'b01 : 2'b10;
      if (idx == 0) begin req_a0 = a; req_b0 = b; end
      else          begin req_a1 = a; req_b1 = b; end
      req_sub[idx] = s;
      req_valid    = oh;
      rsp_ready    = 2'b00;
      #1 chk({tag, ".rdy"}, 32'(req_ready), 32'(oh));
      step();
      req_valid = 2'b00;
      #1 chk({tag, ".exec"}, {29'b0, rsp_valid, busy}, 32'h1);
      step();
      #1 chk({tag, ".vld"}, 32'(rsp_valid), 32'(oh));
      chk({tag, ".res"}, rsp_result, exp_res);
      rsp_ready = oh;
      step();
      rsp_ready = 2'b00;
      #1 chk({tag, ".done"}, {29'b0, rsp_valid, busy}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      req_valid = 2'b11;
      req_sub   = 2'b00;
      rsp_ready = 2'b11;
      req_a0 = 32'h3F80_0000; req_b0 = 32'h4000_0000;
      req_a1 = 32'h4040_0000; req_b1 = 32'h3F80_0000;
      step(); step();
      #1 chk("rst.req_ready", 32'(req_ready), 32'h0);
      chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst.result", rsp_result, 32'h0);
      chk("rst.busy", 32'(busy), 32'h0);
      chk("rst.fx_ready", 32'(fx_req_ready), 32'h0);

      // Tie from the first cycle after reset: 1+2 on req0, 3-1 on req1.
      req_sub = 2'b10;
      reset   = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         g = (k % 2 == 0) ? 2'b01 : 2'b10;
         chk("rr.grant", 32'(req_ready), 32'(g));
         chk("fx.grant", 32'(fx_req_ready), 32'h1);
         step();
         step();
         #1 chk("rr.vld", 32'(rsp_valid), 32'(g));
         chk("rr.res", rsp_result, (k % 2 == 0) ? 32'h4040_0000 : 32'h4000_0000);
         chk("rr.resp_rdy", 32'(req_ready), 32'h0);
         chk("fx.vld", 32'(fx_rsp_valid), 32'h1);
         chk("fx.res", fx_rsp_result, 32'h4040_0000);
         step();
         #1;
      end
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_sub   = 2'b00;
      #1;

      run_op(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, "add12");
      run_op(1, 32'hBFC0_0000, 32'h3E80_0000, 1'b0, 32'hBFA0_0000, "mix_sign");
      run_op(0, 32'h4120_0000, 32'h4120_0000, 1'b1, 32'h0000_0000, "cancel");

      // Backpressure with request inputs changing underneath.
      req_a1 = 32'h4040_0000; req_b1 = 32'h3F80_0000; req_sub = 2'b10;
      req_valid = 2'b10; rsp_ready = 2'b00;
      #1 chk("bp.rdy", 32'(req_ready), 32'h2);
      step();
      req_a1 = 32'h1234_5678; req_b1 = 32'hDEAD_BEEF; req_sub = 2'b00; req_valid = 2'b11;
      #1 chk("bp.exec_rdy", 32'(req_ready), 32'h0);
      step();
      for (int k = 0; k < 5; k++) begin
         #1 chk("bp.vld", 32'(rsp_valid), 32'h2);
         chk("bp.res", rsp_result, 32'h4000_0000);
         chk("bp.req_ready", 32'(req_ready), 32'h0);
         req_a1 = req_a1 + 32'h0101_0101;
         req_a0 = req_a0 ^ 32'hFFFF_0000;
         step();
      end
      req_valid = 2'b00; rsp_ready = 2'b10;
      #1 chk("bp.res_end", rsp_result, 32'h4000_0000);
      step();
      rsp_ready = 2'b00;
      #1 chk("bp.done", {29'b0, rsp_valid, busy}, 32'h0);

      // Non-owner rsp_ready and EXEC-phase rsp_ready are ignored.
      req_a0 = 32'h3F80_0000; req_b0 = 32'h3F80_0000; req_sub = 2'b00; req_valid = 2'b01;
      #1 chk("nb.rdy", 32'(req_ready), 32'h1);
      step();
      req_valid = 2'b00; rsp_ready = 2'b11;
      #1 chk("nb.exec", {29'b0, rsp_valid, busy}, 32'h1);
      step();
      rsp_ready = 2'b10;
      for (int k = 0; k < 3; k++) begin
         #1 chk("nb.hold", 32'(rsp_valid), 32'h1);
         step();
      end
      rsp_ready = 2'b01;
      #1 chk("nb.res", rsp_result, 32'h4000_0000);
      step();
      rsp_ready = 2'b00;
      #1 chk("nb.done", {29'b0, rsp_valid, busy}, 32'h0);

      // Reset pulsed during EXEC aborts the operation.
      req_a0 = 32'h4000_0000; req_b0 = 32'h4000_0000; req_valid = 2'b01;
      #1;
      step();
      reset = 1'b1;
      #1 chk("ab.vld", 32'(rsp_valid), 32'h0);
      chk("ab.busy", 32'(busy), 32'h0);
      chk("ab.res", rsp_result, 32'h0);
      chk("ab.req_ready", 32'(req_ready), 32'h0);
      step();
      reset = 1'b0; req_valid = 2'b00;
      #1;
      step();
      #1 chk("ab.post1", {29'b0, rsp_valid, busy}, 32'h0);
      step();
      #1 chk("ab.post2", {29'b0, rsp_valid, busy}, 32'h0);

      run_op(0, 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
